// File: rtl/sync_bus_edge_filt.sv
// rtl/sync_bus_edge_filt.sv - multi-channel CDC synchroniser with glitch filter, edge pulses and sticky flags
// Each channel is independent; multi-bit values crossing here must be Gray coded or handshaked upstream.
module sync_bus_edge_filt #(
  parameter int   WIDTH         = 4,
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RESET_VAL     = 1'b0,
  parameter int   EDGE_MODE     = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] flag_clr,
  output logic [WIDTH-1:0] q_synced,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_flag
);

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("sync_bus_edge_filt: STAGES must be >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("sync_bus_edge_filt: WIDTH must be >= 1");
    end
    if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("sync_bus_edge_filt: EDGE_MODE must be 0, 1 or 2");
    end
  endgenerate

  localparam int CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;

  // Pure flop chain: nothing may sit between these stages.
  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0]             s_out;
  logic [WIDTH-1:0]             q_sync;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{{WIDTH{RESET_VAL}}}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s_out = sync_q[STAGES-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_nofilt
      assign q_sync = s_out;
    end else begin : g_filt
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
      logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
      logic [WIDTH-1:0]            filt_q;
      logic [WIDTH-1:0]            filt_d;

      // A disagreement must survive FILTER_CYCLES+1 consecutive cycles to be accepted.
      always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
          if (s_out[i] == filt_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            filt_d[i] = s_out[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          filt_q <= {WIDTH{RESET_VAL}};
          cnt_q  <= '0;
        end else begin
          filt_q <= filt_d;
          cnt_q  <= cnt_d;
        end
      end

      assign q_sync = filt_q;
    end
  endgenerate

  logic [WIDTH-1:0] q_prev_q;
  logic [WIDTH-1:0] q_prev_d;
  logic [WIDTH-1:0] flag_q;
  logic [WIDTH-1:0] flag_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] sel;

  assign rise = q_sync & ~q_prev_q;
  assign fall = ~q_sync & q_prev_q;

  // A set coinciding with a clear wins so no event is lost.
  always_comb begin
    q_prev_d = q_sync;
    if (EDGE_MODE == 0) begin
      sel = rise;
    end else if (EDGE_MODE == 1) begin
      sel = fall;
    end else begin
      sel = rise | fall;
    end
    flag_d = sel | (flag_q & ~flag_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_prev_q <= {WIDTH{RESET_VAL}};
      flag_q   <= '0;
    end else begin
      q_prev_q <= q_prev_d;
      flag_q   <= flag_d;
    end
  end

  assign q_synced   = q_sync;
  assign rise_pulse = rise;
  assign fall_pulse = fall;
  assign event_flag = flag_q;

endmodule
